// File: rtl/clock_pkg.sv
// Shared types and widths for the clock display path: serializer FSM states
// and the display word width used by the decoder and the serializer.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SH_LO = 2'd1,
    SH_HI = 2'd2,
    LATCH = 2'd3
  } ser_state_t;

  localparam int DISP_W = 24;

  // Cycles a single frame keeps busy high: two half-periods per bit plus the latch pulse.
  function automatic int frame_cycles(input int data_w, input int clk_div);
    return (2 * data_w + 1) * clk_div;
  endfunction

endpackage

// File: rtl/shreg_serializer.sv
// Shifts display words MSB-first into chained 74HC595-style registers and latches them.
// Optional build macro: SHREG_BLANK_DURING_SHIFT_EN (blank OE# while a frame is shifting).
module shreg_serializer
  import clock_pkg::*;
#(
  parameter int DATA_W  = DISP_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              d_valid,
  output logic              busy,
  output logic              overrun,
  output logic              ser_data,
  output logic              ser_clk,
  output logic              ser_latch,
  output logic              ser_oe_n
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

  // Handshake: d_valid is a one-cycle strobe with no ready; data is only
  // sampled in that cycle. Words arriving while busy go to the pending slot.

  ser_state_t        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_pend;
  logic              r_pend_v;
  logic              r_armed;
  logic              r_busy;
  logic              r_overrun;
  logic              r_ser_data;
  logic              r_ser_clk;
  logic              r_ser_latch;
  logic              r_ser_oe_n;

  ser_state_t        w_state_nxt;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_pend_nxt;
  logic              w_pend_v_nxt;
  logic              w_armed_nxt;
  logic              w_overrun_nxt;
  logic              w_div_done;
  logic              w_shifting_nxt;
  logic              w_oe_n_nxt;

  assign w_div_done = (r_div == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_v  <= w_pend_v_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_pend_nxt    = r_pend;
    w_pend_v_nxt  = r_pend_v;
    w_armed_nxt   = r_armed;
    w_overrun_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        // A fresh strobe beats an older pending word; the pending one is dropped.
        if (d_valid) begin
          w_shift_nxt   = data;
          w_bit_cnt_nxt = CNT_LOAD;
          w_div_nxt     = DIV_LOAD;
          w_pend_v_nxt  = 1'b0;
          w_state_nxt   = SH_LO;
        end else if (r_pend_v) begin
          w_shift_nxt   = r_pend;
          w_bit_cnt_nxt = CNT_LOAD;
          w_div_nxt     = DIV_LOAD;
          w_pend_v_nxt  = 1'b0;
          w_state_nxt   = SH_LO;
        end
      end
      SH_LO: begin
        if (w_div_done) begin
          w_div_nxt   = DIV_LOAD;
          w_state_nxt = SH_HI;
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      SH_HI: begin
        if (w_div_done) begin
          w_div_nxt = DIV_LOAD;
          if (r_bit_cnt == '0) begin
            w_state_nxt = LATCH;
          end else begin
            w_shift_nxt   = r_shift << 1;
            w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
            w_state_nxt   = SH_LO;
          end
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      LATCH: begin
        if (w_div_done) begin
          w_armed_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if ((r_state != IDLE) && d_valid) begin
      w_pend_nxt    = data;
      w_pend_v_nxt  = 1'b1;
      w_overrun_nxt = r_pend_v;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  assign w_shifting_nxt = (w_state_nxt == SH_LO) || (w_state_nxt == SH_HI);

`ifdef SHREG_BLANK_DURING_SHIFT_EN
  assign w_oe_n_nxt = (w_state_nxt != IDLE) || !w_armed_nxt;
`else
  assign w_oe_n_nxt = !w_armed_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_ser_data  <= 1'b0;
      r_ser_clk   <= 1'b0;
      r_ser_latch <= 1'b0;
      r_ser_oe_n  <= 1'b1;
    end else begin
      r_busy      <= (w_state_nxt != IDLE);
      r_overrun   <= w_overrun_nxt;
      r_ser_data  <= w_shifting_nxt ? w_shift_nxt[DATA_W-1] : 1'b0;
      r_ser_clk   <= (w_state_nxt == SH_HI);
      r_ser_latch <= (w_state_nxt == LATCH);
      r_ser_oe_n  <= w_oe_n_nxt;
    end
  end

  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign ser_data  = r_ser_data;
  assign ser_clk   = r_ser_clk;
  assign ser_latch = r_ser_latch;
  assign ser_oe_n  = r_ser_oe_n;

endmodule

// File: tb/tb_shreg_serializer.sv
// Bench for shreg_serializer: frame-level reference model, per-cycle compare,
// received-word scoreboard and directed literal checks. Honours SHREG_BLANK_DURING_SHIFT_EN.
module tb_shreg_serializer;
  import clock_pkg::*;

  localparam int DW    = 24;
  localparam int D     = 2;
  localparam int SHIFT = 2 * DW * D;
  localparam int FRAME = frame_cycles(DW, D);

  logic          clk = 1'b0;
  logic          rst;
  logic          d_valid;
  logic [DW-1:0] data;
  logic          busy, overrun, ser_data, ser_clk, ser_latch, ser_oe_n;

  shreg_serializer #(.DATA_W(DW), .CLK_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .d_valid   (d_valid),
    .busy      (busy),
    .overrun   (overrun),
    .ser_data  (ser_data),
    .ser_clk   (ser_clk),
    .ser_latch (ser_latch),
    .ser_oe_n  (ser_oe_n)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is a cycle counter t from 0 to FRAME-1: bit k occupies t in
  // [2kD, 2kD+2D), low half then high half; the last D cycles are the latch.
  bit            m_ok = 0;
  bit            m_active, m_pend_v, m_latched, m_ov;
  int            m_t;
  logic [DW-1:0] m_word, m_pend;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_active = 0; m_t = 0; m_pend_v = 0; m_latched = 0; m_ov = 0;
      exp_q.delete();
    end else begin
      m_ov = 0;
      if (m_active && d_valid) begin
        m_ov     = m_pend_v;
        m_pend   = data;
        m_pend_v = 1;
      end
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) begin
          m_active  = 0;
          m_latched = 1;
        end
      end else if (d_valid || m_pend_v) begin
        m_word   = d_valid ? data : m_pend;
        m_pend_v = 0;
        m_active = 1;
        m_t      = 0;
        exp_q.push_back(m_word);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      check("busy", busy, m_active);
      check("overrun", overrun, m_ov);
      check("ser_clk", ser_clk, m_active && m_t < SHIFT && ((m_t / D) % 2 == 1));
      check("ser_latch", ser_latch, m_active && m_t >= SHIFT);
`ifdef SHREG_BLANK_DURING_SHIFT_EN
      check("ser_oe_n", ser_oe_n, m_active || !m_latched);
`else
      check("ser_oe_n", ser_oe_n, !m_latched);
`endif
      if (m_active && m_t < SHIFT)
        check("ser_data", ser_data, m_word[DW-1 - m_t / (2 * D)]);
    end
  end

  // ---------------- board-side monitor / scoreboard ----------------
  logic          prev_clk = 0, prev_latch = 0;
  logic [DW-1:0] cap = '0;
  int            frame_bits = 0;
  int            n_rise = 0, n_latch_cyc = 0, n_ov = 0;
  logic [DW-1:0] rx_q[$];
  int            rx_bits_q[$];
  logic [DW-1:0] exp_w;

  always @(negedge clk) begin
    if (rst) begin
      frame_bits = 0;
      cap        = '0;
    end else begin
      if (ser_clk && !prev_clk) begin
        cap = {cap[DW-2:0], ser_data};
        frame_bits++;
        n_rise++;
      end
      if (ser_latch) n_latch_cyc++;
      if (overrun) n_ov++;
      if (ser_latch && !prev_latch) begin
        rx_q.push_back(cap);
        rx_bits_q.push_back(frame_bits);
        check("frame_bits", frame_bits, DW);
        if (exp_q.size() == 0) begin
          check("spurious_latch", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("frame_word", cap, exp_w);
        end
        frame_bits = 0;
      end
    end
    prev_clk   = ser_clk;
    prev_latch = ser_latch;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    data    = w;
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    data    = DW'($urandom);
  endtask

  task automatic clear_obs();
    n_rise = 0; n_latch_cyc = 0; n_ov = 0;
    rx_q.delete();
    rx_bits_q.delete();
  endtask

  // Done once busy has been low for 3 cycles (the inter-frame gap is only 1).
  task automatic wait_idle(input string name, input int budget);
    int idle = 0;
    int i    = 0;
    while (idle < 3 && i < budget) begin
      step();
      idle = busy ? 0 : idle + 1;
      i++;
    end
    if (idle < 3) check({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt, idle, gap;
    logic oe_gap, oe_f2;
    logic [DW-1:0] w;

    rst = 1'b1; d_valid = 1'b0; data = '0;
    step(5);
    rst = 1'b0;
    step();

    // 1: reset values and a quiet serial clock
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_ser_clk", ser_clk, 0);
    check("rst_ser_latch", ser_latch, 0);
    check("rst_ser_oe_n", ser_oe_n, 1);
    clear_obs();
    step(20);
    check("rst_no_sclk", n_rise, 0);

    // 2: single frame A5C31F
    clear_obs();
    send(24'hA5C31F);
    check("f1_oe_n_start", ser_oe_n, 1);
    cnt = 0;
    while (busy && cnt < 500) begin
      cnt++;
      step();
    end
    check("f1_busy_cycles", cnt, 98);
    check("f1_rises", n_rise, 24);
    check("f1_latch_cycles", n_latch_cyc, 2);
    check("f1_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("f1_word", rx_q[0], 24'hA5C31F);
    check("f1_oe_n_after", ser_oe_n, 0);
    step(3);

    // 3: second word arrives mid-frame, goes out after one idle cycle
    clear_obs();
    send(24'h000001);
    step(9);
    send(24'hFFFFFE);
    idle = 0; gap = -1; oe_gap = 1'bx; oe_f2 = 1'bx;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!busy) begin
        idle++;
        if (gap < 0 && idle == 1) oe_gap = ser_oe_n;
      end else begin
        if (idle > 0 && gap < 0) begin
          gap   = idle;
          oe_f2 = ser_oe_n;
        end
        idle = 0;
      end
      if (idle >= 3 && gap >= 0) break;
    end
    check("f3_gap", gap, 1);
    check("f3_oe_n_gap", oe_gap, 0);
`ifdef SHREG_BLANK_DURING_SHIFT_EN
    check("f3_oe_n_frame2", oe_f2, 1);
`else
    check("f3_oe_n_frame2", oe_f2, 0);
`endif
    check("f3_overrun", n_ov, 0);
    check("f3_rx_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check("f3_word0", rx_q[0], 24'h000001);
      check("f3_word1", rx_q[1], 24'hFFFFFE);
    end

    // 4: three strobes in one frame, middle one overwritten
    clear_obs();
    send(24'h111111);
    step(9);
    send(24'h222222);
    step(9);
    send(24'h333333);
    wait_idle("f4", 600);
    check("f4_overrun", n_ov, 1);
    check("f4_rx_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check("f4_word0", rx_q[0], 24'h111111);
      check("f4_word1", rx_q[1], 24'h333333);
    end

    // 5: reset during bit 12 aborts without a latch pulse
    clear_obs();
    send(24'h5A5A5A);
    step(48);
    check("f5_mid_busy", busy, 1);
    rst = 1'b1;
    step();
    check("f5_rst_ser_clk", ser_clk, 0);
    check("f5_rst_ser_latch", ser_latch, 0);
    check("f5_rst_ser_oe_n", ser_oe_n, 1);
    check("f5_rst_busy", busy, 0);
    rst = 1'b0;
    step(20);
    check("f5_no_latch", n_latch_cyc, 0);
    check("f5_rx_empty", rx_q.size(), 0);
    send(24'h0F0F0F);
    wait_idle("f5", 300);
    check("f5_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) begin
      check("f5_word", rx_q[0], 24'h0F0F0F);
      check("f5_bits", rx_bits_q[0], 24);
    end

    // random traffic: gaps from back-to-back up to just over a frame
    for (int k = 0; k < 40; k++) begin
      w = DW'($urandom);
      send(w);
      step($urandom_range(0, 120));
    end
    wait_idle("rand", 1000);
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
